// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Holds the access-size codes, the FSM state type and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Size code 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory responder: load extraction with
// sign/zero extension, and store merging into the existing word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword
);

  function automatic logic [31:0] read_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: read_extract = {{24{sext & b[7]}}, b};
      SZ_HALF: read_extract = {{16{sext & h[15]}}, h};
      default: read_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] write_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] w;
    w = old;
    case (size)
      SZ_BYTE: w[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    write_merge = w;
  endfunction

  assign o_rdata = read_extract(i_word, i_lane, i_size, i_sext);
  assign o_wword = write_merge(i_word, i_wdata, i_lane, i_size);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures a load/store from the memory
// stage, stalls the pipeline for LATENCY cycles, then completes in DONE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        stall,
  output logic        misalign
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [AW+1:0]     r_addr;
  logic [1:0]        r_size;
  logic              r_sext;
  logic              r_write;
  logic              r_mis;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_req;
  logic              w_capture;
  logic              w_mis_now;
  logic [31:0]       w_old;
  logic [31:0]       w_rdata;
  logic [31:0]       w_merged;
  logic              w_unused_addr;

  assign w_req         = (memread | memwrite) & ~rst;
  assign w_mis_now     = is_misaligned(size, address[1:0]);
  assign w_old         = r_mem[r_addr[AW+1:2]];
  assign w_unused_addr = ^address[31:AW+2];

  dmem_lane_align u_align (
    .i_word  (w_old),
    .i_wdata (r_wdata),
    .i_lane  (r_addr[1:0]),
    .i_size  (r_size),
    .i_sext  (r_sext),
    .o_rdata (w_rdata),
    .o_wword (w_merged)
  );

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    stall     = 1'b0;
    ready     = 1'b0;
    misalign  = 1'b0;
    readdata  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          stall     = 1'b1;
          w_capture = 1'b1;
          w_next    = (w_mis_now || LATENCY == 1) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (r_cnt == CNT_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        // Combinational read here gives the pre-write value on a read+write.
        ready    = 1'b1;
        misalign = r_mis;
        readdata = r_mis ? '0 : w_rdata;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == ST_BUSY) ? r_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_addr  <= address[AW+1:0];
      r_size  <= size;
      r_sext  <= sign_ext;
      r_write <= memwrite;
      r_mis   <= w_mis_now;
      r_wdata <= writedata;
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == ST_DONE && r_write && !r_mis && !rst)
      r_mem[r_addr[AW+1:2]] <= w_merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2, 4 and 1.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic        chk_rd;
    logic [31:0] val;
    logic        mis;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst_i [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [1:0]  sz    [3];
  logic        se    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic        stl   [3];
  logic        mis   [3];

  logic [31:0] mdl [3][1024];
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clock(clock), .rst(rst_i[0]), .memread(rd[0]), .memwrite(wr[0]), .size(sz[0]),
    .sign_ext(se[0]), .address(addr[0]), .writedata(wd[0]), .readdata(rdata[0]),
    .ready(rdy[0]), .stall(stl[0]), .misalign(mis[0]));

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_l4 (
    .clock(clock), .rst(rst_i[1]), .memread(rd[1]), .memwrite(wr[1]), .size(sz[1]),
    .sign_ext(se[1]), .address(addr[1]), .writedata(wd[1]), .readdata(rdata[1]),
    .ready(rdy[1]), .stall(stl[1]), .misalign(mis[1]));

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clock(clock), .rst(rst_i[2]), .memread(rd[2]), .memwrite(wr[2]), .size(sz[2]),
    .sign_ext(se[2]), .address(addr[2]), .writedata(wd[2]), .readdata(rdata[2]),
    .ready(rdy[2]), .stall(stl[2]), .misalign(mis[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic ref_mis(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'b00) return 1'b0;
    if (s == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] s, input logic sx);
    logic [31:0] sh;
    if (s == 2'b00) begin
      sh = w >> (8 * a[1:0]);
      return (sx && sh[7]) ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
    end
    if (s == 2'b01) begin
      sh = w >> (16 * a[1]);
      return (sx && sh[15]) ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [31:0] a, input logic [1:0] s);
    logic [31:0] m;
    if (s == 2'b00)      m = 32'h0000_00FF << (8 * a[1:0]);
    else if (s == 2'b01) m = 32'h0000_FFFF << (16 * a[1]);
    else                 m = 32'hFFFF_FFFF;
    return (old & ~m) | ((d << (8 * a[1:0])) & m);
  endfunction

  task automatic idle_inputs(input int k);
    rd[k] = 1'b0; wr[k] = 1'b0; sz[k] = 2'b00; se[k] = 1'b0;
    addr[k] = '0; wd[k] = '0;
  endtask

  // Drives one request on instance k and waits for its completion.
  task automatic access(input int k, input logic w, input logic r, input logic [1:0] s,
                        input logic sx, input logic [31:0] a, input logic [31:0] d,
                        input int lat);
    exp_t e;
    int   idx;
    int   cyc;
    bit   done;
    idx      = int'(a[11:2]);
    e.mis    = ref_mis(s, a);
    e.chk_rd = r;
    e.lat    = e.mis ? 1 : lat;
    e.val    = e.mis ? 32'h0 : ref_load(mdl[k][idx], a, s, sx);
    exp_q.push_back(e);
    if (w && !e.mis) mdl[k][idx] = ref_store(mdl[k][idx], d, a, s);
    rd[k] = r; wr[k] = w; sz[k] = s; se[k] = sx; addr[k] = a; wd[k] = d;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 20) begin
      @(negedge clock);
      if (rdy[k]) begin
        e = exp_q.pop_front();
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("misalign", {31'b0, mis[k]}, {31'b0, e.mis});
        chk("stall_at_ready", {31'b0, stl[k]}, 32'h0);
        if (e.chk_rd) chk("readdata", rdata[k], e.val);
        done = 1;
      end else begin
        chk("stall_busy", {31'b0, stl[k]}, 32'h1);
        chk("readdata_idle", rdata[k], 32'h0);
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (!done) chk("timeout", 32'h0, 32'h1);
    idle_inputs(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rv;
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b1;
      idle_inputs(k);
    end
    rd[0] = 1'b1;
    addr[0] = 32'h10;
    sz[0] = SZ_WORD;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", {31'b0, stl[k]}, 32'h0);
      chk("rst_ready", {31'b0, rdy[k]}, 32'h0);
      chk("rst_misalign", {31'b0, mis[k]}, 32'h0);
      chk("rst_readdata", rdata[k], 32'h0);
    end
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) rst_i[k] = 1'b0;
    idle_inputs(0);
    @(posedge clock); #1;

    // LATENCY=2: word, byte/half merge and extract, misalign, wrap, read-before-write
    access(0, 1, 0, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 2);
    access(0, 0, 1, SZ_WORD, 0, 32'h10, 32'h0, 2);
    access(0, 1, 0, SZ_WORD, 0, 32'h20, 32'h11223344, 2);
    access(0, 1, 0, SZ_BYTE, 0, 32'h21, 32'h555555AA, 2);
    access(0, 0, 1, SZ_WORD, 0, 32'h20, 32'h0, 2);
    access(0, 0, 1, SZ_BYTE, 1, 32'h21, 32'h0, 2);
    access(0, 0, 1, SZ_BYTE, 0, 32'h21, 32'h0, 2);
    access(0, 0, 1, SZ_HALF, 0, 32'h22, 32'h0, 2);
    access(0, 0, 1, SZ_HALF, 1, 32'h20, 32'h0, 2);
    access(0, 0, 1, SZ_WORD, 0, 32'h22, 32'h0, 2);
    access(0, 1, 0, SZ_HALF, 0, 32'h21, 32'hFFFF, 2);
    access(0, 0, 1, SZ_WORD, 0, 32'h20, 32'h0, 2);
    access(0, 1, 0, SZ_HALF, 0, 32'h26, 32'h0000BEEF, 2);
    access(0, 0, 1, SZ_HALF, 1, 32'h26, 32'h0, 2);
    access(0, 1, 0, SZ_WORD, 0, 32'h0, 32'h0, 2);
    access(0, 1, 0, SZ_WORD, 0, 32'h1000, 32'h5, 2);
    access(0, 0, 1, SZ_WORD, 0, 32'h0, 32'h0, 2);
    access(0, 1, 1, SZ_WORD, 0, 32'h10, 32'h01020304, 2);
    access(0, 0, 1, SZ_WORD, 0, 32'h10, 32'h0, 2);
    access(0, 0, 1, 2'b11, 0, 32'h10, 32'h0, 2);

    // LATENCY=4: reset during an in-flight store aborts it
    access(1, 1, 0, SZ_WORD, 0, 32'h30, 32'h0, 4);
    wr[1] = 1'b1; sz[1] = SZ_WORD; addr[1] = 32'h30; wd[1] = 32'hCAFEF00D;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_i[1] = 1'b1;
    idle_inputs(1);
    @(posedge clock); #1;
    rst_i[1] = 1'b0;
    @(negedge clock);
    chk("abort_stall", {31'b0, stl[1]}, 32'h0);
    chk("abort_ready", {31'b0, rdy[1]}, 32'h0);
    chk("abort_readdata", rdata[1], 32'h0);
    @(posedge clock); #1;
    access(1, 0, 1, SZ_WORD, 0, 32'h30, 32'h0, 4);

    // LATENCY=1: back-to-back traffic against the reference model
    for (int i = 0; i < 8; i++)
      access(2, 1, 0, SZ_WORD, 0, 32'h40 + 32'(4 * i), $urandom, 1);
    for (int i = 0; i < 16; i++) begin
      ra = 32'h40 + 32'(4 * $urandom_range(0, 7));
      rv = $urandom;
      if (i % 2 == 0) access(2, 1, 0, SZ_WORD, 0, ra, rv, 1);
      else            access(2, 0, 1, SZ_WORD, 0, ra, 32'h0, 1);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
